fsm_seq_tx: RTL and testbench



---
 rtl/fsm_seq_tx.sv | 187 ++++++++++++++++++
 tb/tb_fsm_seq_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_tx.sv
// fsm_seq_tx -- serial sequence transmitter (Moore FSM, registered outputs).
//
// On an accepted start request the block sends a fixed sync preamble, then
// the captured payload word MSB first, then GAP_LEN guard cycles at 0.
// After the final guard cycle it pulses done for one cycle.
//
// Optional feature: define SEQ_TX_PARITY_EN to insert one even-parity bit
// (state PAR, code 3'b100) between the payload and the gap. This also widens
// Estado to 3 bits.
//
// Parameters:
//   DATA_W   payload width, 1..32
//   PRE_W    preamble length, 1..8
//   PREAMBLE preamble pattern, sent MSB first
//   GAP_LEN  guard cycles after each frame, 1..15
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    frame request, sampled only in IDLE
//   data_in  payload, captured on the cycle start is accepted
//   Out_1    serial line (registered)
//   busy     frame or gap in progress (registered)
//   done     one-cycle pulse after the last gap cycle (registered)
//   Estado   current state code, for debug
module fsm_seq_tx #(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 3,
  parameter logic [PRE_W-1:0]  PREAMBLE = 3'b101,
  parameter int                GAP_LEN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              Out_1,
  output logic              busy,
  output logic              done,
`ifdef SEQ_TX_PARITY_EN
  output logic [2:0]        Estado
`else
  output logic [1:0]        Estado
`endif
);

`ifdef SEQ_TX_PARITY_EN
  localparam int ST_W = 3;
`else
  localparam int ST_W = 2;
`endif

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W = $clog2(max3(PRE_W, DATA_W + 1, GAP_LEN)) + 1;

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [ST_W-1:0] {
    IDLE = 3'b000,
    PRE  = 3'b001,
    DATA = 3'b010,
    GAP  = 3'b011,
    PAR  = 3'b100
  } state_t;
`else
  typedef enum logic [ST_W-1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    DATA = 2'b10,
    GAP  = 2'b11
  } state_t;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sh;
`ifdef SEQ_TX_PARITY_EN
  logic               par;
`endif

  // Preamble bit that follows the one emitted at count c. Shifting the
  // pattern instead of indexing keeps the index non-negative for PRE_W = 1.
  function automatic logic pre_next(input logic [CNT_W-1:0] c);
    logic [PRE_W-1:0] p;
    p = PREAMBLE << (int'(c) + 1);
    return p[PRE_W-1];
  endfunction

  assign Estado = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      Out_1 <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      sh    <= '0;
`ifdef SEQ_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          Out_1 <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          if (start) begin
            sh    <= data_in;
`ifdef SEQ_TX_PARITY_EN
            par   <= ^data_in;
`endif
            state <= PRE;
            busy  <= 1'b1;
            Out_1 <= PREAMBLE[PRE_W-1];
          end
        end

        PRE: begin
          if (cnt == PRE_LAST) begin
            // First payload bit goes out as we enter DATA; the register
            // shifts so its MSB is always the next bit to send.
            state <= DATA;
            cnt   <= '0;
            Out_1 <= sh[DATA_W-1];
            sh    <= sh << 1;
          end else begin
            cnt   <= cnt + 1'b1;
            Out_1 <= pre_next(cnt);
          end
        end

        DATA: begin
          if (cnt == DATA_LAST) begin
            cnt   <= '0;
`ifdef SEQ_TX_PARITY_EN
            state <= PAR;
            Out_1 <= par;
`else
            state <= GAP;
            Out_1 <= 1'b0;
`endif
          end else begin
            cnt   <= cnt + 1'b1;
            Out_1 <= sh[DATA_W-1];
            sh    <= sh << 1;
          end
        end

`ifdef SEQ_TX_PARITY_EN
        PAR: begin
          state <= GAP;
          cnt   <= '0;
          Out_1 <= 1'b0;
        end
`endif

        GAP: begin
          Out_1 <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          Out_1 <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_seq_tx.sv
// Testbench for fsm_seq_tx (default parameters). A table of frames is
// applied in a loop; each accepted frame pushes its per-cycle expected
// outputs to a queue, and every sampled cycle pops one entry (idle when
// the queue is empty). Hand-written sequences cover reset/idle and
// reset colliding with start.
module tb_fsm_seq_tx;

`ifdef SEQ_TX_PARITY_EN
  localparam int ST_W = 3;
`else
  localparam int ST_W = 2;
`endif

  localparam logic [ST_W-1:0] S_IDLE = 0;
  localparam logic [ST_W-1:0] S_PRE  = 1;
  localparam logic [ST_W-1:0] S_DATA = 2;
  localparam logic [ST_W-1:0] S_GAP  = 3;
  localparam logic [ST_W-1:0] S_PAR  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [7:0]      data_in;
  logic            Out_1;
  logic            busy;
  logic            done;
  logic [ST_W-1:0] Estado;

  fsm_seq_tx dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .Out_1   (Out_1),
    .busy    (busy),
    .done    (done),
    .Estado  (Estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            out;
    logic            busy;
    logic            done;
    logic [ST_W-1:0] st;
  } exp_t;

  // mode: 0 single frame, 1 start pulsed mid-payload, 2 three back-to-back
  // frames with start held high, 3 reset on payload bit 3
  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
    int          mode;
  } vec_t;

  exp_t  q[$];
  int    n_vec  = 0;
  int    n_fail = 0;
  string tag;

  task automatic push(input logic o, input logic b, input logic d,
                      input logic [ST_W-1:0] s);
    exp_t e;
    e.out = o; e.busy = b; e.done = d; e.st = s;
    q.push_back(e);
  endtask

  // Expected outputs of one frame plus its done cycle.
  task automatic push_frame(input logic [7:0] d, input logic [11:0] f);
    for (int j = 0; j < 3; j++) push(f[11-j], 1'b1, 1'b0, S_PRE);
    for (int j = 0; j < 8; j++) push(f[8-j], 1'b1, 1'b0, S_DATA);
`ifdef SEQ_TX_PARITY_EN
    push(^d, 1'b1, 1'b0, S_PAR);
`else
    if (d === 8'hxx) push(1'b0, 1'b0, 1'b0, S_IDLE);
`endif
    push(f[0], 1'b1, 1'b0, S_GAP);
    push(1'b0, 1'b0, 1'b1, S_IDLE);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) e = q.pop_front();
    else begin
      e.out = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.st = S_IDLE;
    end
    n_vec++;
    if (Out_1 !== e.out || busy !== e.busy || done !== e.done || Estado !== e.st) begin
      n_fail++;
      $display("FAIL %s @%0t: got out=%b busy=%b done=%b st=%0d, want out=%b busy=%b done=%b st=%0d",
               tag, $time, Out_1, busy, done, Estado, e.out, e.busy, e.done, e.st);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 12'b101_10100101_0, 0};
    vecs[1] = '{8'hFF, 12'b101_11111111_0, 1};
    vecs[2] = '{8'h3C, 12'b101_00111100_0, 2};
    vecs[3] = '{8'h81, 12'b101_10000001_0, 3};
    vecs[4] = '{8'h00, 12'b101_00000000_0, 0};
    vecs[5] = '{8'h07, 12'b101_00000111_0, 0};

    // Reset held 2 cycles, then idle with start low.
    tag = "reset_idle";
    rst = 1'b1; start = 1'b0; data_in = 8'h00;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();

    for (int v = 0; v < 6; v++) begin
      tag = $sformatf("vec%0d_%02h", v, vecs[v].data);
      data_in = vecs[v].data;
      start   = 1'b1;
      push_frame(vecs[v].data, vecs[v].frame);
      case (vecs[v].mode)
        1: begin
          step();
          start = 1'b0;
          for (int i = 0; i < 4; i++) step();
          // Second request with a different word lands in the payload.
          data_in = 8'h00; start = 1'b1;
          step();
          start = 1'b0;
          while (q.size() > 0) step();
        end
        2: begin
          push_frame(vecs[v].data, vecs[v].frame);
          push_frame(vecs[v].data, vecs[v].frame);
          while (q.size() > 1) step();
          start = 1'b0;
          step();
        end
        3: begin
          step();
          start = 1'b0;
          for (int i = 0; i < 5; i++) step();
          data_in = 8'h5A;
          rst = 1'b1;
          q.delete();
          step();
          rst = 1'b0;
        end
        default: begin
          step();
          start = 1'b0;
          data_in = ~vecs[v].data;
          while (q.size() > 0) step();
        end
      endcase
      for (int i = 0; i < 3; i++) step();
    end

    // rst and start at the same edge: reset wins, start dropped.
    tag = "rst_start";
    rst = 1'b1; start = 1'b1; data_in = 8'hC3;
    step();
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
